id_ex_stage: RTL

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/riscv_pkg.sv | 19 +
 rtl/id_ex_stage_fwd_mux.sv | 35 +++
 rtl/id_ex_stage.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: ALU opcode encodings and register-address width.
package riscv_pkg;

  localparam int unsigned RA_W = 5;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_SLL  = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_XOR  = 4'b0110,
    ALU_SRL  = 4'b0111,
    ALU_SRA  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alu_ctrl_e;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand forwarding select: x0 reads zero, then MEM writeback, then WB writeback, else the given data.
module fwd_mux #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned RA_W   = 5,
  parameter bit          FWD_EN = 1'b1
) (
  input  logic [RA_W-1:0]  rs_i,
  input  logic [WIDTH-1:0] rs_data_i,
  input  logic [RA_W-1:0]  mem_rd_i,
  input  logic             mem_reg_write_i,
  input  logic [WIDTH-1:0] mem_result_i,
  input  logic [RA_W-1:0]  wb_rd_i,
  input  logic             wb_reg_write_i,
  input  logic [WIDTH-1:0] wb_result_i,
  output logic [WIDTH-1:0] data_o
);

  logic mem_hit;
  logic wb_hit;

  assign mem_hit = mem_reg_write_i && (mem_rd_i == rs_i);
  assign wb_hit  = wb_reg_write_i && (wb_rd_i == rs_i);

  always_comb begin
    data_o = rs_data_i;
    if (rs_i == '0) begin
      data_o = '0;
    end else if (FWD_EN && mem_hit) begin
      data_o = mem_result_i;
    end else if (FWD_EN && wb_hit) begin
      data_o = wb_result_i;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with valid/ready handshake, operand forwarding and hazard stall.
// Build option: define ID_EX_FORWARDING_EN for forwarding; otherwise stall on any pending writer.
module id_ex_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned RA_W  = riscv_pkg::RA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  output logic             id_ready,
  input  logic [RA_W-1:0]  id_rs1,
  input  logic [RA_W-1:0]  id_rs2,
  input  logic [RA_W-1:0]  id_rd,
  input  logic [WIDTH-1:0] id_rs1_data,
  input  logic [WIDTH-1:0] id_rs2_data,
  input  logic [WIDTH-1:0] id_imm,
  input  logic [WIDTH-1:0] id_pc,
  input  logic [3:0]       id_alu_ctrl,
  input  logic             id_src_a,
  input  logic             id_src_b,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic [RA_W-1:0]  mem_rd,
  input  logic             mem_reg_write,
  input  logic [WIDTH-1:0] mem_result,
  input  logic [RA_W-1:0]  wb_rd,
  input  logic             wb_reg_write,
  input  logic [WIDTH-1:0] wb_result,
  input  logic             flush,
  output logic             ex_valid,
  input  logic             ex_ready,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_ctrl,
  output logic [RA_W-1:0]  ex_rd,
  output logic             ex_reg_write,
  output logic             ex_mem_read,
  output logic [WIDTH-1:0] ex_store_data,
  output logic [WIDTH-1:0] ex_pc
);

  import riscv_pkg::*;

`ifdef ID_EX_FORWARDING_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  logic             valid_q,     valid_d;
  logic [RA_W-1:0]  rs1_q,       rs1_d;
  logic [RA_W-1:0]  rs2_q,       rs2_d;
  logic [RA_W-1:0]  rd_q,        rd_d;
  logic [WIDTH-1:0] rs1_data_q,  rs1_data_d;
  logic [WIDTH-1:0] rs2_data_q,  rs2_data_d;
  logic [WIDTH-1:0] imm_q,       imm_d;
  logic [WIDTH-1:0] pc_q,        pc_d;
  alu_ctrl_e        alu_ctrl_q,  alu_ctrl_d;
  logic             src_a_q,     src_a_d;
  logic             src_b_q,     src_b_d;
  logic             reg_write_q, reg_write_d;
  logic             mem_read_q,  mem_read_d;

  logic [WIDTH-1:0] id_rs1_fwd, id_rs2_fwd;
  logic [WIDTH-1:0] ex_rs1_fwd, ex_rs2_fwd;
  logic             hazard;
  logic             capture;

  function automatic logic rs_hit(input logic [RA_W-1:0] rd, input logic we,
                                  input logic [RA_W-1:0] rs);
    return we && (rd == rs) && (rs != '0);
  endfunction

  fwd_mux #(.WIDTH(WIDTH), .RA_W(RA_W), .FWD_EN(FWD_EN)) u_fwd_id_rs1 (
    .rs_i(id_rs1), .rs_data_i(id_rs1_data),
    .mem_rd_i(mem_rd), .mem_reg_write_i(mem_reg_write), .mem_result_i(mem_result),
    .wb_rd_i(wb_rd), .wb_reg_write_i(wb_reg_write), .wb_result_i(wb_result),
    .data_o(id_rs1_fwd)
  );

  fwd_mux #(.WIDTH(WIDTH), .RA_W(RA_W), .FWD_EN(FWD_EN)) u_fwd_id_rs2 (
    .rs_i(id_rs2), .rs_data_i(id_rs2_data),
    .mem_rd_i(mem_rd), .mem_reg_write_i(mem_reg_write), .mem_result_i(mem_result),
    .wb_rd_i(wb_rd), .wb_reg_write_i(wb_reg_write), .wb_result_i(wb_result),
    .data_o(id_rs2_fwd)
  );

  fwd_mux #(.WIDTH(WIDTH), .RA_W(RA_W), .FWD_EN(FWD_EN)) u_fwd_ex_rs1 (
    .rs_i(rs1_q), .rs_data_i(rs1_data_q),
    .mem_rd_i(mem_rd), .mem_reg_write_i(mem_reg_write), .mem_result_i(mem_result),
    .wb_rd_i(wb_rd), .wb_reg_write_i(wb_reg_write), .wb_result_i(wb_result),
    .data_o(ex_rs1_fwd)
  );

  fwd_mux #(.WIDTH(WIDTH), .RA_W(RA_W), .FWD_EN(FWD_EN)) u_fwd_ex_rs2 (
    .rs_i(rs2_q), .rs_data_i(rs2_data_q),
    .mem_rd_i(mem_rd), .mem_reg_write_i(mem_reg_write), .mem_result_i(mem_result),
    .wb_rd_i(wb_rd), .wb_reg_write_i(wb_reg_write), .wb_result_i(wb_result),
    .data_o(ex_rs2_fwd)
  );

`ifdef ID_EX_FORWARDING_EN
  // Only a load in EX cannot be forwarded in time.
  assign hazard = rs_hit(rd_q, valid_q && mem_read_q, id_rs1) ||
                  rs_hit(rd_q, valid_q && mem_read_q, id_rs2);
`else
  assign hazard = rs_hit(rd_q,   valid_q && reg_write_q, id_rs1) ||
                  rs_hit(rd_q,   valid_q && reg_write_q, id_rs2) ||
                  rs_hit(mem_rd, mem_reg_write,          id_rs1) ||
                  rs_hit(mem_rd, mem_reg_write,          id_rs2) ||
                  rs_hit(wb_rd,  wb_reg_write,           id_rs1) ||
                  rs_hit(wb_rd,  wb_reg_write,           id_rs2);
`endif

  assign id_ready = (!valid_q || ex_ready) && !hazard && !flush;
  assign capture  = id_valid && id_ready;

  always_comb begin
    valid_d     = valid_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rd_d        = rd_q;
    rs1_data_d  = rs1_data_q;
    rs2_data_d  = rs2_data_q;
    imm_d       = imm_q;
    pc_d        = pc_q;
    alu_ctrl_d  = alu_ctrl_q;
    src_a_d     = src_a_q;
    src_b_d     = src_b_q;
    reg_write_d = reg_write_q;
    mem_read_d  = mem_read_q;

    if (flush) begin
      valid_d = 1'b0;
    end else if (capture) begin
      valid_d = 1'b1;
    end else if (valid_q && ex_ready) begin
      valid_d = 1'b0;
    end

    if (capture) begin
      rs1_d       = id_rs1;
      rs2_d       = id_rs2;
      rd_d        = id_rd;
      rs1_data_d  = id_rs1_fwd;
      rs2_data_d  = id_rs2_fwd;
      imm_d       = id_imm;
      pc_d        = id_pc;
      alu_ctrl_d  = alu_ctrl_e'(id_alu_ctrl);
      src_a_d     = id_src_a;
      src_b_d     = id_src_b;
      reg_write_d = id_reg_write;
      mem_read_d  = id_mem_read;
    end else if (FWD_EN && valid_q && !ex_ready && !flush) begin
      // Absorb writebacks while stalled so a value retiring from WB is not lost.
      rs1_data_d = ex_rs1_fwd;
      rs2_data_d = ex_rs2_fwd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      pc_q        <= '0;
      alu_ctrl_q  <= ALU_ADD;
      src_a_q     <= 1'b0;
      src_b_q     <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      imm_q       <= imm_d;
      pc_q        <= pc_d;
      alu_ctrl_q  <= alu_ctrl_d;
      src_a_q     <= src_a_d;
      src_b_q     <= src_b_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
    end
  end

  assign ex_valid      = valid_q;
  assign alu_a         = src_a_q ? pc_q  : ex_rs1_fwd;
  assign alu_b         = src_b_q ? imm_q : ex_rs2_fwd;
  assign ex_store_data = ex_rs2_fwd;
  assign alu_ctrl      = alu_ctrl_q;
  assign ex_rd         = rd_q;
  assign ex_pc         = pc_q;
  assign ex_reg_write  = valid_q && reg_write_q;
  assign ex_mem_read   = valid_q && mem_read_q;

endmodule
